// File: rtl/spi_aes_slave_pkg.sv
// Shared command codes, FSM states and frame-length constants for the SPI/AES slave.
package aes_spi_pkg;

  localparam logic [7:0] CMD_WR_ENC = 8'hA5;
  localparam logic [7:0] CMD_WR_DEC = 8'h5A;
  localparam logic [7:0] CMD_RD     = 8'h3C;

  localparam int unsigned DATA_BITS   = 128;
  localparam int unsigned STATUS_BITS = 8;
  localparam int unsigned CNT_W       = 9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_RX_DATA,
    ST_RX_KEY,
    ST_RX_DONE,
    ST_BUSY,
    ST_TX_STATUS,
    ST_TX_RESULT,
    ST_DRAIN
  } state_t;

  // Key field length in bits for a key of nk 32-bit words.
  function automatic int unsigned key_bits(input int unsigned nk);
    return nk * 32;
  endfunction

endpackage

// File: rtl/spi_aes_slave_if.sv
// SPI pins plus the AES core handshake, grouped as one bundle.
interface spi_aes_slave_if #(
  parameter int unsigned Nk = 4
);
  logic            sclk;
  logic            cs;
  logic            mosi;
  logic            miso;
  logic [127:0]    aes_data;
  logic [Nk*32-1:0] aes_key;
  logic            aes_encrypt;
  logic            aes_start;
  logic            aes_done;
  logic [127:0]    aes_result;

  modport slave (
    input  sclk, cs, mosi, aes_done, aes_result,
    output miso, aes_data, aes_key, aes_encrypt, aes_start
  );

  modport master (
    output sclk, cs, mosi, aes_done, aes_result,
    input  miso, aes_data, aes_key, aes_encrypt, aes_start
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the async input through the chain and keep one extra flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= STAGES'({sync_q, din});
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign dout   = sync_q[STAGES-1];
  assign rise_c = dout & ~prev_q;
  assign fall_c = ~dout & prev_q;

endmodule

// File: rtl/spi_aes_slave.sv
// SPI mode-0 slave that collects a command, block and key, launches the AES core,
// and returns the captured result in a separate read frame.
module spi_aes_slave
  import aes_spi_pkg::*;
#(
  parameter int unsigned Nk          = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_slave,
  input  logic                  rst,
  spi_aes_slave_if.slave        bus,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int unsigned KEY_BITS = key_bits(Nk);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk_slave), .rst(rst), .din(bus.sclk), .dout(sclk_s), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk_slave), .rst(rst), .din(bus.cs), .dout(cs_s), .rise_c(cs_rise), .fall_c(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk_slave), .rst(rst), .din(bus.mosi), .dout(mosi_s), .rise_c(mosi_rise), .fall_c(mosi_fall)
  );

  // cs is handled by level so a frame boundary is never missed; only sclk edges drive the shifters.
  assign unused_edges = &{1'b0, sclk_s, cs_rise, cs_fall, mosi_rise, mosi_fall};

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           cmd_sh;
  logic [DATA_BITS-1:0] data_sh;
  logic [KEY_BITS-1:0]  key_sh;
  logic [DATA_BITS-1:0] tx_sh;
  logic [DATA_BITS-1:0] result_q;
  logic                 rd_done_q;
  logic                 rd_valid_q;

  logic [7:0] cmd_word;
  state_t     rest_state;
  logic       shift_cmd_c, shift_data_c, shift_key_c, launch_c, err_c;
  logic       load_status_c, load_result_c, set_rd_done_c, clear_valid_c;
  logic       tx_active;

  assign cmd_word   = {cmd_sh[6:0], mosi_s};
  assign rest_state = busy ? ST_BUSY : ST_IDLE;
  assign tx_active  = (state_q == ST_TX_STATUS) || (state_q == ST_TX_RESULT);

  // State and bit-counter register.
  always_ff @(posedge clk_slave) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame sequencing: next state, bit count and datapath strobes.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_cmd_c   = 1'b0;
    shift_data_c  = 1'b0;
    shift_key_c   = 1'b0;
    launch_c      = 1'b0;
    err_c         = 1'b0;
    load_status_c = 1'b0;
    load_result_c = 1'b0;
    set_rd_done_c = 1'b0;
    clear_valid_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_BUSY: begin
        if (!cs_s) begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end
      end
      ST_CMD: begin
        if (cs_s) begin
          err_c   = 1'b1;
          state_d = rest_state;
        end else if (sclk_rise) begin
          shift_cmd_c = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) begin
            cnt_d = '0;
            case (cmd_word)
              CMD_WR_ENC, CMD_WR_DEC: begin
                if (busy) begin
                  err_c   = 1'b1;
                  state_d = ST_DRAIN;
                end else begin
                  state_d = ST_RX_DATA;
                end
              end
              CMD_RD: begin
                load_status_c = 1'b1;
                state_d       = ST_TX_STATUS;
              end
              default: begin
                err_c   = 1'b1;
                state_d = ST_DRAIN;
              end
            endcase
          end
        end
      end
      ST_RX_DATA: begin
        if (cs_s) begin
          err_c   = 1'b1;
          state_d = rest_state;
        end else if (sclk_rise) begin
          shift_data_c = 1'b1;
          cnt_d        = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
            cnt_d   = '0;
            state_d = ST_RX_KEY;
          end
        end
      end
      ST_RX_KEY: begin
        if (cs_s) begin
          err_c   = 1'b1;
          state_d = rest_state;
        end else if (sclk_rise) begin
          shift_key_c = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(KEY_BITS - 1)) begin
            cnt_d   = '0;
            state_d = ST_RX_DONE;
          end
        end
      end
      ST_RX_DONE: begin
        if (cs_s) begin
          launch_c = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_TX_STATUS: begin
        if (cs_s) begin
          state_d = rest_state;
        end else if (sclk_rise) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(STATUS_BITS - 1)) begin
            cnt_d         = '0;
            load_result_c = 1'b1;
            state_d       = ST_TX_RESULT;
          end
        end
      end
      ST_TX_RESULT: begin
        if (cs_s) begin
          clear_valid_c = rd_done_q & rd_valid_q;
          state_d       = rest_state;
        end else if (sclk_rise && !rd_done_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
            set_rd_done_c = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (cs_s) begin
          state_d = rest_state;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow shifters, AES launch/capture, status flags and the miso shifter.
  always_ff @(posedge clk_slave) begin
    if (!rst) begin
      cmd_sh          <= '0;
      data_sh         <= '0;
      key_sh          <= '0;
      tx_sh           <= '0;
      result_q        <= '0;
      rd_done_q       <= 1'b0;
      rd_valid_q      <= 1'b0;
      bus.aes_data    <= '0;
      bus.aes_key     <= '0;
      bus.aes_encrypt <= 1'b0;
      bus.aes_start   <= 1'b0;
      bus.miso        <= 1'b0;
      result_valid    <= 1'b0;
      busy            <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      bus.aes_start <= launch_c;
      frame_err     <= err_c;
      if (shift_cmd_c)  cmd_sh  <= cmd_word;
      if (shift_data_c) data_sh <= {data_sh[DATA_BITS-2:0], mosi_s};
      if (shift_key_c)  key_sh  <= {key_sh[KEY_BITS-2:0], mosi_s};
      if (launch_c) begin
        bus.aes_data    <= data_sh;
        bus.aes_key     <= key_sh;
        bus.aes_encrypt <= (cmd_sh == CMD_WR_ENC);
        busy            <= 1'b1;
        result_valid    <= 1'b0;
      end
      if (load_status_c) begin
        tx_sh <= {result_valid, busy, 6'b0, (DATA_BITS - STATUS_BITS)'(0)};
      end else if (load_result_c) begin
        tx_sh      <= result_valid ? result_q : '0;
        rd_valid_q <= result_valid;
        rd_done_q  <= 1'b0;
      end else if (sclk_fall && tx_active && !cs_s) begin
        tx_sh <= {tx_sh[DATA_BITS-2:0], 1'b0};
      end
      if (set_rd_done_c) rd_done_q <= 1'b1;
      if (clear_valid_c) result_valid <= 1'b0;
      if (cs_s || !tx_active) begin
        bus.miso <= 1'b0;
      end else if (sclk_fall) begin
        bus.miso <= tx_sh[DATA_BITS-1];
      end
      if (busy && bus.aes_done) begin
        result_q     <= bus.aes_result;
        result_valid <= 1'b1;
        busy         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_aes_slave.sv
// Directed bench for spi_aes_slave: SPI master driver, small AES core stand-in, per-scenario tasks.
module tb_spi_aes_slave;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst;
  logic result_valid, busy, frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int done_delay = 20;
  int start_cnt = 0;
  int err_cnt = 0;
  int miso_ones = 0;

  spi_aes_slave_if #(.Nk(4)) bus ();

  spi_aes_slave #(.Nk(4), .SYNC_STAGES(2)) dut (
    .clk_slave   (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .result_valid(result_valid),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  // Event counters sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.aes_start === 1'b1) start_cnt++;
    if (frame_err === 1'b1)     err_cnt++;
    if (bus.miso === 1'b1)      miso_ones++;
  end

  // AES core stand-in: answers the FIPS-197 vector pair after done_delay cycles.
  initial begin
    logic [127:0] res;
    bus.aes_done   = 1'b0;
    bus.aes_result = '0;
    forever begin
      @(negedge clk);
      if (bus.aes_start === 1'b1) begin
        if (bus.aes_encrypt && bus.aes_data == PT && bus.aes_key == KEY)      res = CT;
        else if (!bus.aes_encrypt && bus.aes_data == CT && bus.aes_key == KEY) res = PT;
        else                                                                   res = '1;
        repeat (done_delay) @(negedge clk);
        bus.aes_result = res;
        bus.aes_done   = 1'b1;
        @(negedge clk);
        bus.aes_done   = 1'b0;
      end
    end
  end

  // Mode-0 master: shifts the top nbits of stream MSB first, samples miso on each sclk rise.
  task automatic spi_frame(input logic [263:0] stream, input int nbits, input bit end_cs,
                           output logic [143:0] rx);
    rx = '0;
    bus.cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = stream[263-i];
      repeat (5) @(negedge clk);
      bus.sclk = 1'b1;
      rx = {rx[142:0], bus.miso};
      repeat (5) @(negedge clk);
      bus.sclk = 1'b0;
    end
    if (end_cs) begin
      repeat (5) @(negedge clk);
      bus.cs   = 1'b1;
      bus.mosi = 1'b0;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (result_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", frame_err); end
    n_checks++; if (bus.miso !== 1'b0 || bus.aes_start !== 1'b0) begin n_errors++; $display("FAIL reset_miso_start: got %b %b want 0 0", bus.miso, bus.aes_start); end
    n_checks++; if (bus.aes_data !== '0 || bus.aes_key !== '0 || bus.aes_encrypt !== 1'b0) begin n_errors++; $display("FAIL reset_aes: got %h %h %b want 0", bus.aes_data, bus.aes_key, bus.aes_encrypt); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_encrypt();
    logic [143:0] rx;
    int s0, e0, n;
    done_delay = 20;
    s0 = start_cnt; e0 = err_cnt;
    spi_frame({8'hA5, PT, KEY}, 264, 1'b1, rx);
    n_checks++; if (start_cnt - s0 !== 1) begin n_errors++; $display("FAIL enc_start_count: got %0d want 1", start_cnt - s0); end
    n_checks++; if (bus.aes_encrypt !== 1'b1) begin n_errors++; $display("FAIL enc_flag: got %b want 1", bus.aes_encrypt); end
    n_checks++; if (bus.aes_data !== PT) begin n_errors++; $display("FAIL enc_data: got %h want %h", bus.aes_data, PT); end
    n_checks++; if (bus.aes_key !== KEY) begin n_errors++; $display("FAIL enc_key: got %h want %h", bus.aes_key, KEY); end
    n_checks++; if (busy !== 1'b1 || err_cnt != e0) begin n_errors++; $display("FAIL enc_busy_err: got busy=%b errs=%0d want 1 0", busy, err_cnt - e0); end
    n = 0;
    while (result_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    n_checks++; if (result_valid !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL enc_done: got valid=%b busy=%b want 1 0", result_valid, busy); end
    spi_frame({8'h3C, 256'h0}, 144, 1'b1, rx);
    n_checks++; if (rx[135:128] !== 8'h80) begin n_errors++; $display("FAIL enc_status: got %h want 80", rx[135:128]); end
    n_checks++; if (rx[127:0] !== CT) begin n_errors++; $display("FAIL enc_result: got %h want %h", rx[127:0], CT); end
    n_checks++; if (result_valid !== 1'b0) begin n_errors++; $display("FAIL enc_valid_clear: got %b want 0", result_valid); end
  endtask

  task automatic test_decrypt();
    logic [143:0] rx;
    int s0, n;
    done_delay = 20;
    s0 = start_cnt;
    spi_frame({8'h5A, CT, KEY}, 264, 1'b1, rx);
    n_checks++; if (start_cnt - s0 !== 1 || bus.aes_encrypt !== 1'b0) begin n_errors++; $display("FAIL dec_start: got starts=%0d enc=%b want 1 0", start_cnt - s0, bus.aes_encrypt); end
    n_checks++; if (bus.aes_data !== CT) begin n_errors++; $display("FAIL dec_data: got %h want %h", bus.aes_data, CT); end
    n = 0;
    while (result_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    n_checks++; if (result_valid !== 1'b1) begin n_errors++; $display("FAIL dec_done: got %b want 1", result_valid); end
    spi_frame({8'h3C, 256'h0}, 144, 1'b1, rx);
    n_checks++; if (rx[135:0] !== {8'h80, PT}) begin n_errors++; $display("FAIL dec_read: got %h want %h", rx[135:0], {8'h80, PT}); end
  endtask

  task automatic test_abort();
    logic [143:0] rx;
    int s0, e0, m0;
    s0 = start_cnt; e0 = err_cnt;
    spi_frame({8'hA5, PT, KEY}, 8 + 70, 1'b1, rx);
    n_checks++; if (err_cnt - e0 !== 1) begin n_errors++; $display("FAIL abort_err: got %0d want 1", err_cnt - e0); end
    n_checks++; if (start_cnt != s0 || bus.aes_data !== CT) begin n_errors++; $display("FAIL abort_no_start: got starts=%0d data=%h want 0 %h", start_cnt - s0, bus.aes_data, CT); end
    e0 = err_cnt; m0 = miso_ones;
    spi_frame({8'hFF, 256'hFFFF}, 24, 1'b1, rx);
    n_checks++; if (err_cnt - e0 !== 1) begin n_errors++; $display("FAIL badcmd_err: got %0d want 1", err_cnt - e0); end
    n_checks++; if (miso_ones != m0 || start_cnt != s0) begin n_errors++; $display("FAIL badcmd_quiet: got miso_ones=%0d starts=%0d want 0 0", miso_ones - m0, start_cnt - s0); end
  endtask

  task automatic test_busy_read();
    logic [143:0] rx;
    int s0, e0, n;
    done_delay = 2500;
    s0 = start_cnt;
    spi_frame({8'hA5, PT, KEY}, 264, 1'b1, rx);
    spi_frame({8'h3C, 256'h0}, 144, 1'b1, rx);
    n_checks++; if (rx[135:128] !== 8'h40) begin n_errors++; $display("FAIL busy_status: got %h want 40", rx[135:128]); end
    n_checks++; if (rx[127:0] !== '0) begin n_errors++; $display("FAIL busy_result: got %h want 0", rx[127:0]); end
    e0 = err_cnt;
    spi_frame({8'h5A, CT, KEY}, 16, 1'b1, rx);
    n_checks++; if (err_cnt - e0 !== 1 || start_cnt - s0 !== 1) begin n_errors++; $display("FAIL busy_write: got errs=%0d starts=%0d want 1 1", err_cnt - e0, start_cnt - s0); end
    n_checks++; if (busy !== 1'b1 || bus.aes_data !== PT) begin n_errors++; $display("FAIL busy_inflight: got busy=%b data=%h want 1 %h", busy, bus.aes_data, PT); end
    n = 0;
    while (result_valid !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
    n_checks++; if (result_valid !== 1'b1) begin n_errors++; $display("FAIL busy_done: got %b want 1", result_valid); end
    spi_frame({8'h3C, 256'h0}, 40, 1'b1, rx);
    n_checks++; if (rx[31:0] !== {8'h80, CT[127:104]}) begin n_errors++; $display("FAIL partial_bits: got %h want %h", rx[31:0], {8'h80, CT[127:104]}); end
    n_checks++; if (result_valid !== 1'b1) begin n_errors++; $display("FAIL partial_keep: got %b want 1", result_valid); end
    spi_frame({8'h3C, 256'h0}, 144, 1'b1, rx);
    n_checks++; if (rx[135:0] !== {8'h80, CT}) begin n_errors++; $display("FAIL full_after_partial: got %h want %h", rx[135:0], {8'h80, CT}); end
    n_checks++; if (result_valid !== 1'b0) begin n_errors++; $display("FAIL full_clear: got %b want 0", result_valid); end
  endtask

  task automatic test_reset_mid();
    logic [143:0] rx;
    int s0, n;
    s0 = start_cnt;
    spi_frame({8'hA5, CT, KEY}, 8 + 128 + 40, 1'b0, rx);
    rst = 1'b0; bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (bus.aes_data !== '0 || bus.aes_key !== '0 || busy !== 1'b0 || frame_err !== 1'b0) begin n_errors++; $display("FAIL rst_rxkey: got data=%h key=%h busy=%b err=%b want 0", bus.aes_data, bus.aes_key, busy, frame_err); end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (start_cnt != s0) begin n_errors++; $display("FAIL rst_rxkey_start: got %0d want 0", start_cnt - s0); end
    done_delay = 200;
    spi_frame({8'hA5, PT, KEY}, 264, 1'b1, rx);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || bus.aes_data !== '0 || bus.aes_encrypt !== 1'b0 || bus.aes_start !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got busy=%b data=%h enc=%b want 0", busy, bus.aes_data, bus.aes_encrypt); end
    rst = 1'b1;
    repeat (300) @(negedge clk);
    n_checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL late_done: got valid=%b busy=%b want 0 0", result_valid, busy); end
    done_delay = 20;
    s0 = start_cnt;
    spi_frame({8'h5A, CT, KEY}, 264, 1'b1, rx);
    n = 0;
    while (result_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    n_checks++; if (start_cnt - s0 !== 1 || result_valid !== 1'b1) begin n_errors++; $display("FAIL fresh_frame: got starts=%0d valid=%b want 1 1", start_cnt - s0, result_valid); end
    spi_frame({8'h3C, 256'h0}, 144, 1'b1, rx);
    n_checks++; if (rx[135:0] !== {8'h80, PT}) begin n_errors++; $display("FAIL fresh_read: got %h want %h", rx[135:0], {8'h80, PT}); end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_abort();
    test_busy_read();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
